// File: rtl/hash_out_stream_pkg.sv
// Shared definitions for the BLAKE2 pin I/O transmit path.
// Holds digest sizing, the receiver command encodings and the output FSM states.
package hash_out_stream_pkg;

    localparam int HASH_BYTES = 64;
    localparam int CNT_W      = 6;
    localparam int HASH_W     = 8 * HASH_BYTES;

    // Command encodings shared with the byte-serial receiver.
    typedef enum logic [1:0] {
        CMD_CONFIG = 2'd0,
        CMD_DATA   = 2'd1,
        CMD_FINAL  = 2'd2,
        CMD_RESET  = 2'd3
    } cmd_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    // Index of the final byte; a length of 0 stands for a full digest and
    // wraps to HASH_BYTES-1.
    function automatic logic [CNT_W-1:0] last_index(input logic [CNT_W-1:0] len);
        return len - CNT_W'(1);
    endfunction

endpackage

// File: rtl/hash_out_stream_out_shift_reg.sv
// Digest holding register: parallel load, then shifts one byte right per
// transfer so the next byte to send always sits in the low 8 bits.
module hash_out_stream_out_shift_reg
    import hash_out_stream_pkg::*;
#(
    parameter int N_BYTES = HASH_BYTES
) (
    input  logic                   clk,
    input  logic                   i_load,
    input  logic                   i_shift,
    input  logic [8*N_BYTES-1:0]   i_data,
    output logic [7:0]             o_byte
);

    logic [8*N_BYTES-1:0] r_shift;

    // Deliberately unreset: contents are only visible while the stream FSM is
    // in SEND, which always follows a load.
    always_ff @(posedge clk) begin
        if (i_load) begin
            r_shift <= i_data;
        end else if (i_shift) begin
            r_shift <= {8'h00, r_shift[8*N_BYTES-1:8]};
        end
    end

    assign o_byte = r_shift[7:0];

endmodule

// File: rtl/hash_out_stream.sv
// Transmit side of the BLAKE2 pin interface: captures a finished digest and
// streams its first nn bytes out under a valid/ready handshake.
//
// state  | meaning
// S_IDLE | waiting for a finished pulse from the hash core
// S_SEND | presenting digest bytes, one per accepted transfer
module hash_out_stream
    import hash_out_stream_pkg::*;
(
    input  logic                clk,
    input  logic                nreset,
    input  logic                en_i,
    input  logic                hash_finished_i,
    input  logic [HASH_W-1:0]   hash_i,
    input  logic [CNT_W-1:0]    nn_i,
    input  logic                ready_i,
    output logic                data_v_o,
    output logic [7:0]          data_o,
    output logic                last_o,
    output logic                busy_o,
    output logic                overrun_o
);

    logic             r_en_q;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_len;
    logic             r_overrun;

    logic             w_fin;
    logic             w_sending;
    logic             w_load;
    logic             w_xfer;
    logic             w_at_last;
    logic [7:0]       w_byte;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_en_q <= 1'b0;
        end else begin
            r_en_q <= en_i;
        end
    end

    assign w_fin     = r_en_q & hash_finished_i;
    assign w_sending = (r_state == S_SEND);
    assign w_load    = w_fin & (r_state == S_IDLE);
    assign w_xfer    = r_en_q & w_sending & ready_i;
    assign w_at_last = (r_cnt == last_index(r_len));

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_load)              w_state_nxt = S_SEND;
            S_SEND: if (w_xfer && w_at_last) w_state_nxt = S_IDLE;
            default:                         w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        data_v_o = r_en_q & w_sending;
        last_o   = r_en_q & w_sending & w_at_last;
        data_o   = w_sending ? w_byte : 8'h00;
        busy_o   = w_sending;
    end

    // Counter wraps from 63 to 0 only on a full 64-byte stream, which is
    // exactly when the FSM leaves SEND.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_cnt <= '0;
            r_len <= '0;
        end else if (w_load) begin
            r_cnt <= '0;
            r_len <= nn_i;
        end else if (w_xfer) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // A digest finishing mid-stream is dropped, including on the final byte.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_overrun <= 1'b0;
        end else if (w_fin && w_sending) begin
            r_overrun <= 1'b1;
        end
    end

    assign overrun_o = r_overrun;

    hash_out_stream_out_shift_reg #(
        .N_BYTES (HASH_BYTES)
    ) u_shift (
        .clk     (clk),
        .i_load  (w_load),
        .i_shift (w_xfer),
        .i_data  (hash_i),
        .o_byte  (w_byte)
    );

endmodule

// File: tb/tb_hash_out_stream.sv
// Directed bench for hash_out_stream: table of stream shapes plus hand-written
// overrun, enable-gap and mid-stream reset sequences.
module tb_hash_out_stream;

    logic         clk;
    logic         nreset;
    logic         en_i;
    logic         hash_finished_i;
    logic [511:0] hash_i;
    logic [5:0]   nn_i;
    logic         ready_i;
    logic         data_v_o;
    logic [7:0]   data_o;
    logic         last_o;
    logic         busy_o;
    logic         overrun_o;

    int n_cmp = 0;
    int n_err = 0;

    hash_out_stream dut (
        .clk             (clk),
        .nreset          (nreset),
        .en_i            (en_i),
        .hash_finished_i (hash_finished_i),
        .hash_i          (hash_i),
        .nn_i            (nn_i),
        .ready_i         (ready_i),
        .data_v_o        (data_v_o),
        .data_o          (data_o),
        .last_o          (last_o),
        .busy_o          (busy_o),
        .overrun_o       (overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [5:0] nn;
        logic [7:0] base;
        logic [3:0] pat;
        int         exp_len;
        int         exp_cycles;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fill_hash(input logic [7:0] base);
        for (int j = 0; j < 64; j++) hash_i[8*j +: 8] = base + 8'(j);
    endtask

    // Pulse finished for one cycle; byte 0 must be valid right after that edge.
    task automatic start_stream(input logic [5:0] nn, input logic [7:0] base);
        fill_hash(base);
        nn_i            = nn;
        hash_finished_i = 1'b1;
        tick();
        hash_finished_i = 1'b0;
        nn_i            = 6'd17;
        fill_hash(8'hC3);
        check("start_valid", 32'(data_v_o), 32'd1);
        check("start_busy",  32'(busy_o),   32'd1);
    endtask

    task automatic stream(input logic [5:0] nn, input logic [7:0] base, input logic [3:0] pat,
                          input int off_at, input int off_len,
                          input int exp_len, input int exp_cycles, input int exp_gaps);
        int k    = 0;
        int c    = 0;
        int gaps = 0;
        start_stream(nn, base);
        while (k < exp_len && c < 400) begin
            ready_i = pat[c % 4];
            en_i    = !(c >= off_at && c < off_at + off_len);
            if (data_v_o) begin
                check("byte", 32'(data_o), 32'(base + 8'(k)));
                check("last", 32'(last_o), 32'(k == exp_len - 1));
                if (ready_i) k++;
            end else begin
                gaps++;
                check("hold_byte", 32'(data_o), 32'(base + 8'(k)));
                check("hold_last", 32'(last_o), 32'd0);
            end
            tick();
            c++;
        end
        ready_i = 1'b0;
        en_i    = 1'b1;
        check("xfer_count", 32'(k),    32'(exp_len));
        check("cycles",     32'(c),    32'(exp_cycles));
        check("gaps",       32'(gaps), 32'(exp_gaps));
        check("end_valid",  32'(data_v_o), 32'd0);
        check("end_busy",   32'(busy_o),   32'd0);
    endtask

    initial begin
        vecs[0] = '{nn: 6'd32, base: 8'h00, pat: 4'b1111, exp_len: 32, exp_cycles: 32};
        vecs[1] = '{nn: 6'd4,  base: 8'h00, pat: 4'b1001, exp_len: 4,  exp_cycles: 8};
        vecs[2] = '{nn: 6'd0,  base: 8'h00, pat: 4'b1111, exp_len: 64, exp_cycles: 64};
        vecs[3] = '{nn: 6'd1,  base: 8'h50, pat: 4'b1111, exp_len: 1,  exp_cycles: 1};
        vecs[4] = '{nn: 6'd63, base: 8'h80, pat: 4'b0101, exp_len: 63, exp_cycles: 125};
        vecs[5] = '{nn: 6'd16, base: 8'h10, pat: 4'b0110, exp_len: 16, exp_cycles: 31};

        nreset          = 1'b0;
        en_i            = 1'b0;
        hash_finished_i = 1'b0;
        hash_i          = '0;
        nn_i            = '0;
        ready_i         = 1'b0;
        #12;
        check("rst_valid",   32'(data_v_o),  32'd0);
        check("rst_data",    32'(data_o),    32'd0);
        check("rst_last",    32'(last_o),    32'd0);
        check("rst_busy",    32'(busy_o),    32'd0);
        check("rst_overrun", 32'(overrun_o), 32'd0);
        nreset = 1'b1;
        tick();

        // Finished pulse while disabled must be ignored.
        fill_hash(8'h00);
        nn_i            = 6'd8;
        hash_finished_i = 1'b1;
        tick();
        hash_finished_i = 1'b0;
        tick();
        check("gated_busy",  32'(busy_o),   32'd0);
        check("gated_valid", 32'(data_v_o), 32'd0);
        en_i = 1'b1;
        tick();

        // Streams run back to back: each starts in the cycle after the last byte.
        for (int i = 0; i < 6; i++) begin
            stream(vecs[i].nn, vecs[i].base, vecs[i].pat, 0, 0,
                   vecs[i].exp_len, vecs[i].exp_cycles, 0);
        end
        check("no_overrun_yet", 32'(overrun_o), 32'd0);

        // Enable dropped for 5 cycles while byte 7 is presented.
        stream(6'd16, 8'h20, 4'b1111, 7, 5, 16, 21, 5);

        // Overrun: second digest arrives while byte 10 is on the pins.
        start_stream(6'd16, 8'h00);
        ready_i = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check("ovr_valid", 32'(data_v_o), 32'd1);
            check("ovr_byte",  32'(data_o),   32'(k));
            check("ovr_last",  32'(last_o),   32'(k == 15));
            check("ovr_flag",  32'(overrun_o), 32'(k > 10));
            if (k == 10) begin
                for (int j = 0; j < 64; j++) hash_i[8*j +: 8] = 8'hAA;
                nn_i            = 6'd5;
                hash_finished_i = 1'b1;
            end
            tick();
            hash_finished_i = 1'b0;
        end
        ready_i = 1'b0;
        check("ovr_end_busy", 32'(busy_o), 32'd0);
        for (int j = 0; j < 4; j++) begin
            tick();
            check("ovr_no_restart", 32'(data_v_o), 32'd0);
        end
        check("ovr_sticky", 32'(overrun_o), 32'd1);

        // Asynchronous reset while byte 20 is presented.
        start_stream(6'd32, 8'h40);
        ready_i = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        check("pre_rst_byte", 32'(data_o), 32'h54);
        #2;
        nreset = 1'b0;
        #1;
        check("mid_rst_valid",   32'(data_v_o),  32'd0);
        check("mid_rst_data",    32'(data_o),    32'd0);
        check("mid_rst_last",    32'(last_o),    32'd0);
        check("mid_rst_busy",    32'(busy_o),    32'd0);
        check("mid_rst_overrun", 32'(overrun_o), 32'd0);
        ready_i = 1'b0;
        tick();
        tick();
        nreset = 1'b1;
        tick();
        stream(6'd8, 8'h60, 4'b1111, 0, 0, 8, 8, 0);
        check("post_rst_overrun", 32'(overrun_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
